// File: rtl/palette_clut.sv
// rtl/palette_clut.sv - multi-bank runtime colour lookup table with frame-paced bank switch and global fade
module palette_clut #(
    parameter int IDX_W    = 5,
    parameter int CH_W     = 4,
    parameter int NBANK    = 2,
    parameter int NRD      = 2,
    parameter int FADE_DIV = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         wr_en,
    input  logic [$clog2(NBANK)-1:0]     wr_bank,
    input  logic [IDX_W-1:0]             wr_addr,
    input  logic [3*CH_W-1:0]            wr_rgb,
    input  logic                         rd_en,
    input  logic [NRD*IDX_W-1:0]         rd_idx,
    output logic [NRD*3*CH_W-1:0]        rd_rgb,
    output logic                         rd_valid,
    input  logic                         frame_start,
    input  logic                         bank_req,
    input  logic [$clog2(NBANK)-1:0]     bank_sel,
    output logic [$clog2(NBANK)-1:0]     active_bank,
    input  logic                         fade_start,
    input  logic                         fade_dir,
    output logic                         fade_busy,
    output logic                         fade_done,
    output logic [CH_W:0]                fade_level
);

    localparam int BW    = $clog2(NBANK);
    localparam int DEPTH = 1 << IDX_W;
    localparam int AW    = $clog2(NBANK * DEPTH);
    localparam int CW    = $clog2(FADE_DIV + 1);
    localparam int RGB_W = 3 * CH_W;

    localparam logic [BW:0]     NB_LIM   = (BW + 1)'(NBANK);
    localparam logic [CH_W:0]   LVL_MAX  = {1'b1, {CH_W{1'b0}}};
    localparam logic [CH_W:0]   LVL_ZERO = '0;
    localparam logic [CW-1:0]   CNT_LAST = CW'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } fade_state_t;

    // Palette storage: never reset, behaves as plain RAM
    logic [RGB_W-1:0] mem [NBANK*DEPTH];

    logic [BW-1:0]    pending;
    logic             bank_ok;
    logic             wr_ok;
    logic [AW-1:0]    wr_ptr;

    logic             s1_valid;
    logic [RGB_W-1:0] s1_rgb [NRD];

    fade_state_t      state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [CH_W:0]    level_next;
    logic             done_next;
    logic             at_target;
    logic             step;

    function automatic logic [AW-1:0] flat_addr(input logic [BW-1:0] bank, input logic [IDX_W-1:0] idx);
        return AW'(bank) * AW'(DEPTH) + AW'(idx);
    endfunction

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [CH_W:0] lv);
        return CH_W'(({{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, lv}) >> CH_W);
    endfunction

    assign bank_ok = bank_req && ({1'b0, bank_sel} < NB_LIM);
    assign wr_ok   = wr_en && ({1'b0, wr_bank} < NB_LIM);
    assign wr_ptr  = flat_addr(wr_bank, wr_addr);

    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_rgb;
        end
    end

    // Requested bank waits for a frame edge; a request on that same edge takes effect at once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending     <= '0;
            active_bank <= '0;
        end else begin
            if (frame_start) begin
                active_bank <= bank_ok ? bank_sel : pending;
                pending     <= bank_ok ? bank_sel : pending;
            end else if (bank_ok) begin
                pending <= bank_sel;
            end
        end
    end

    // Stage 1 reads the RAM before any same-edge write lands, so read-during-write sees old data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            for (int p = 0; p < NRD; p++) begin
                s1_rgb[p] <= '0;
            end
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                for (int p = 0; p < NRD; p++) begin
                    s1_rgb[p] <= mem[flat_addr(active_bank, rd_idx[p*IDX_W +: IDX_W])];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid <= 1'b0;
            rd_rgb   <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                for (int p = 0; p < NRD; p++) begin
                    for (int ch = 0; ch < 3; ch++) begin
                        rd_rgb[p*RGB_W + ch*CH_W +: CH_W] <= scale(s1_rgb[p][ch*CH_W +: CH_W], fade_level);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            fade_level <= LVL_MAX;
            fade_done  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            fade_level <= level_next;
            fade_done  <= done_next;
        end
    end

    assign at_target = fade_dir ? (fade_level == LVL_MAX) : (fade_level == LVL_ZERO);
    assign step      = frame_start && (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = fade_level;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fade_start) begin
                    if (at_target) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = fade_dir ? ST_FADE_IN : ST_FADE_OUT;
                        cnt_next   = '0;
                    end
                end
            end
            ST_FADE_OUT: begin
                if (step) begin
                    cnt_next   = '0;
                    level_next = fade_level - 1'b1;
                    if (fade_level == LVL_ZERO + 1'b1) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end else if (frame_start) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_FADE_IN: begin
                if (step) begin
                    cnt_next   = '0;
                    level_next = fade_level + 1'b1;
                    if (fade_level == LVL_MAX - 1'b1) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end else if (frame_start) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        fade_busy = 1'b0;
        if (state != ST_IDLE) begin
            fade_busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_palette_clut.sv
// tb/tb_palette_clut.sv - directed self-checking bench for palette_clut
module tb_palette_clut;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [4:0]  wr_addr;
    logic [11:0] wr_rgb;
    logic        rd_en;
    logic [9:0]  rd_idx;
    logic [23:0] rd_rgb;
    logic        rd_valid;
    logic        frame_start;
    logic        bank_req;
    logic [0:0]  bank_sel;
    logic [0:0]  active_bank;
    logic        fade_start;
    logic        fade_dir;
    logic        fade_busy;
    logic        fade_done;
    logic [4:0]  fade_level;

    int total = 0;
    int bad   = 0;

    palette_clut #(
        .IDX_W(5), .CH_W(4), .NBANK(2), .NRD(2), .FADE_DIV(2)
    ) dut (
        .Clk(clk), .Reset(reset),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_rgb(rd_rgb), .rd_valid(rd_valid),
        .frame_start(frame_start), .bank_req(bank_req), .bank_sel(bank_sel),
        .active_bank(active_bank),
        .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy),
        .fade_done(fade_done), .fade_level(fade_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic b, input logic [4:0] a, input logic [11:0] c);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_rgb = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Issue one lookup and return to the cycle where its result is visible
    task automatic lookup(input logic [4:0] i1, input logic [4:0] i0);
        rd_en = 1'b1; rd_idx = {i1, i0};
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; wr_en = 0; wr_bank = 0; wr_addr = 0; wr_rgb = 0;
        rd_en = 0; rd_idx = 0; frame_start = 0; bank_req = 0; bank_sel = 0;
        fade_start = 0; fade_dir = 0;
        tick(); tick();
        check("rst_valid", rd_valid, 0);
        check("rst_rgb", rd_rgb, 0);
        check("rst_bank", active_bank, 0);
        check("rst_level", fade_level, 16);
        check("rst_busy", fade_busy, 0);
        check("rst_done", fade_done, 0);
        reset = 1'b0;
        tick();

        wr(0, 3, 12'hEDA);
        wr(0, 7, 12'h241);
        rd_en = 1'b1; rd_idx = {5'd7, 5'd3};
        tick();
        rd_en = 1'b0;
        check("lat1_valid", rd_valid, 0);
        tick();
        check("basic_valid", rd_valid, 1);
        check("basic_rgb", rd_rgb, 24'h241EDA);
        tick();
        check("basic_valid_off", rd_valid, 0);
        check("basic_hold", rd_rgb, 24'h241EDA);

        wr_en = 1; wr_bank = 0; wr_addr = 3; wr_rgb = 12'h111;
        rd_en = 1; rd_idx = {5'd7, 5'd3};
        tick();
        wr_en = 0; rd_en = 0;
        tick();
        check("rdw_old", rd_rgb[11:0], 12'hEDA);
        lookup(7, 3);
        check("rdw_new", rd_rgb[11:0], 12'h111);

        wr(1, 3, 12'h6A3);
        bank_req = 1; bank_sel = 1;
        tick();
        bank_req = 0;
        check("bank_pending", active_bank, 0);
        lookup(7, 3);
        check("bank_before", rd_rgb[11:0], 12'h111);
        frame();
        check("bank_after", active_bank, 1);
        lookup(7, 3);
        check("bank1_rgb", rd_rgb[11:0], 12'h6A3);
        frame();
        check("bank_stable", active_bank, 1);
        bank_req = 1; bank_sel = 0; frame_start = 1;
        tick();
        bank_req = 0; frame_start = 0;
        check("bank_same_edge", active_bank, 0);
        wr(0, 3, 12'hEDA);

        fade_start = 1; fade_dir = 0;
        tick();
        fade_start = 0;
        check("fo_busy", fade_busy, 1);
        frame();
        check("fo_lvl_1f", fade_level, 16);
        frame();
        check("fo_lvl_2f", fade_level, 15);
        frames(14);
        check("fo_lvl8", fade_level, 8);
        lookup(7, 3);
        check("fo_rgb8", rd_rgb, 24'h120765);
        frames(15);
        check("fo_lvl1", fade_level, 1);
        check("fo_busy_31", fade_busy, 1);
        frame();
        check("fo_lvl0", fade_level, 0);
        check("fo_done", fade_done, 1);
        check("fo_idle", fade_busy, 0);
        tick();
        check("fo_done_off", fade_done, 0);
        lookup(7, 3);
        check("fo_black", rd_rgb, 24'h000000);

        fade_start = 1; fade_dir = 1;
        tick();
        fade_start = 0;
        frames(10);
        check("fi_lvl5", fade_level, 5);
        fade_start = 1; fade_dir = 0;
        tick();
        fade_start = 0;
        check("fi_ignore_busy", fade_busy, 1);
        check("fi_ignore_done", fade_done, 0);
        frames(21);
        check("fi_lvl15", fade_level, 15);
        frame();
        check("fi_lvl16", fade_level, 16);
        check("fi_done", fade_done, 1);
        check("fi_idle", fade_busy, 0);
        fade_start = 1; fade_dir = 1;
        tick();
        fade_start = 0;
        check("fi_attgt_done", fade_done, 1);
        check("fi_attgt_busy", fade_busy, 0);
        tick();
        check("fi_attgt_off", fade_done, 0);

        bank_req = 1; bank_sel = 1; frame_start = 1;
        tick();
        bank_req = 0; frame_start = 0;
        fade_start = 1; fade_dir = 0;
        tick();
        fade_start = 0;
        frames(14);
        check("rs_lvl9", fade_level, 9);
        check("rs_bank1", active_bank, 1);
        lookup(7, 3);
        check("rs_rgb9", rd_rgb[11:0], 12'h351);
        rd_en = 1; rd_idx = {5'd7, 5'd3};
        tick();
        rd_en = 0; reset = 1;
        tick();
        reset = 0;
        check("rs_level", fade_level, 16);
        check("rs_busy", fade_busy, 0);
        check("rs_bank", active_bank, 0);
        check("rs_valid", rd_valid, 0);
        check("rs_rgb", rd_rgb, 0);
        tick();
        check("rs_flush", rd_valid, 0);
        check("rs_flush_rgb", rd_rgb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/palette_clut.md
# palette_clut

Runtime-writable, multi-bank colour lookup table that replaces the fixed per-sprite palette ROMs. Holds NBANK palettes of 2^IDX_W entries, serves NRD independent pixel-index lookups per cycle with a 2-cycle registered pipeline, switches the active bank only on frame boundaries, and applies a frame-paced global fade (brightness scale) to every output colour. Sits between the sprite/background pixel fetch and the VGA colour mapper.

## Interface

- IDX_W, 5, palette index width; 2^IDX_W entries per bank
- CH_W, 4, bits per colour channel
- NBANK, 2, number of palette banks (≥2)
- NRD, 2, number of read ports
- FADE_DIV, 2, frame_start pulses per fade step (≥1)

- Clk  in  1  clock, all logic rising-edge
- Reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe
- wr_bank  in  $clog2(NBANK)  target bank of write
- wr_addr  in  IDX_W  target entry
- wr_rgb  in  3*CH_W  {red, green, blue}
- rd_en  in  1  lookup request, all ports
- rd_idx  in  NRD*IDX_W  port p index at [p*IDX_W +: IDX_W]
- rd_rgb  out  NRD*3*CH_W  port p colour at [p*3*CH_W +: 3*CH_W], {r,g,b}
- rd_valid  out  1  rd_rgb valid for request issued 2 cycles earlier
- frame_start  in  1  one-cycle pulse per frame (from VGA controller)
- bank_req  in  1  request bank change
- bank_sel  in  $clog2(NBANK)  requested bank
- active_bank  out  $clog2(NBANK)  bank used for lookups
- fade_start  in  1  start fade pulse
- fade_dir  in  1  0 = fade out (toward black), 1 = fade in (toward full)
- fade_busy  out  1  fade in progress
- fade_done  out  1  one-cycle pulse on fade completion
- fade_level  out  CH_W+1  current brightness, 0..2^CH_W

## Operation

- Storage: NBANK × 2^IDX_W words of 3*CH_W bits, not cleared by Reset (contents undefined until written).
- Write: wr_en samples wr_bank/wr_addr/wr_rgb at the edge; any bank writable at any time, including active bank.
- Read-during-write, same bank and address: lookup returns old data.
- Bank switch: bank_req loads pending ← bank_sel; repeated requests before a frame_start → last wins. On frame_start, active_bank ← (bank_req ? bank_sel : pending). With no request since the last switch, active_bank is unchanged. bank_sel ≥ NBANK is ignored.
- Lookup uses active_bank value at the cycle rd_en is sampled.
- Fade arithmetic per channel: out = (c × fade_level) >> CH_W, product width 2*CH_W+1; fade_level = 2^CH_W gives out = c exactly, 0 gives 0.
- Fade FSM states IDLE, FADE_OUT, FADE_IN:
  - IDLE + fade_start: if fade_level already at target (0 for out, 2^CH_W for in) stay IDLE, pulse fade_done next cycle; else enter FADE_OUT/FADE_IN, frame counter ← 0.
  - In FADE_*: each frame_start increments counter; on the FADE_DIV-th, counter ← 0 and fade_level ∓ 1.
  - Level reaching target → IDLE, fade_done pulses the following cycle.
  - fade_start while busy: ignored.
- fade_busy = (state ≠ IDLE).

## Timing

- Reset values: rd_rgb 0, rd_valid 0, active_bank 0, pending 0, fade_level 2^CH_W, fade_busy 0, fade_done 0, FSM IDLE, counter 0.
- Latency 2: rd_en at edge N → stage-1 raw colour at N+1 → scaled rd_rgb and rd_valid at N+2. Full throughput, one lookup per port per cycle.
- rd_rgb holds last value when rd_valid is 0.
- Scaling uses fade_level as registered at stage-2 edge.
- Bank change visible to lookups sampled from the cycle after the frame_start edge.
- Reset mid-fade or mid-pipeline: all state to reset values on that edge; in-flight lookups discarded (rd_valid 0 for 2 cycles minimum).

## Test plan

(IDX_W=5, CH_W=4, NBANK=2, NRD=2, FADE_DIV=2)
- Write bank0[3]=0xEDA, bank0[7]=0x241; rd_en, idx {p1=7,p0=3} → 2 cycles later rd_rgb p0=0xEDA, p1=0x241, rd_valid=1 for exactly one cycle.
- Write bank0[3]=0x111 same cycle as lookup of idx 3 → returns 0xEDA; next lookup returns 0x111.
- Write bank1[3]=0x6A3; bank_req sel=1; lookup idx 3 before frame_start → bank0 data; after frame_start → 0x6A3, active_bank=1.
- fade_start dir=0 with bank0[3]=0xEDA: fade_busy=1, level 15 after 2nd frame_start; at level 8 output 0x765; at 32nd frame_start level 0, fade_done one pulse, output 0x000, busy 0.
- fade_start dir=1 from 0, extra fade_start mid-fade ignored → level 16 after 32 frame_starts; fade_start dir=1 at level 16 → fade_done pulse, busy stays 0.
- Reset asserted at level 9 during FADE_OUT with active_bank=1 → level 16, busy 0, active_bank 0, rd_valid 0, rd_rgb 0.
